// File: rtl/seg_display_pkg.sv
// Shared constants and width helper for the multiplexed 7-segment display driver.
package seg_display_pkg;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] PWM_TOP   = 4'd14;

  // Bits needed to hold 0..n-1; never returns 0 so single-digit builds still get a real register.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_display_scan_hex2seg.sv
// Hex nibble to active-low a..g segment pattern; bit 6 = a, bit 0 = g.
module hex2seg (
  input  logic [3:0] i_num,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_num)
      4'h0: o_seg = 7'h01;
      4'h1: o_seg = 7'h4F;
      4'h2: o_seg = 7'h12;
      4'h3: o_seg = 7'h06;
      4'h4: o_seg = 7'h4C;
      4'h5: o_seg = 7'h24;
      4'h6: o_seg = 7'h20;
      4'h7: o_seg = 7'h0F;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h04;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h60;
      4'hC: o_seg = 7'h31;
      4'hD: o_seg = 7'h42;
      4'hE: o_seg = 7'h30;
      4'hF: o_seg = 7'h38;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed hex display scanner: slot divider, frame-latched shadows, LZ blanking, PWM dimming.
module seg_display_scan
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1250
) (
  input  logic                    clk5,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] dispVal,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [7:0]              digit,
  output logic [7:0]              segment,
  output logic                    frame_tick
);

  localparam int DIV_W = clog2(DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);

  logic [DIV_W-1:0]        r_div_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [3:0]              r_pwm_cnt;
  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_blank;
  logic [3:0]              r_bright;

  logic                    w_slot_tick;
  logic                    w_frame_end;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_zero_above;
  logic [3:0]              w_nib;
  logic                    w_dp_lit;
  logic                    w_slot_vis;
  logic                    w_on;
  logic                    w_vis;
  logic [6:0]              w_seg;

  assign w_slot_tick = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_frame_end = w_slot_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Walk down from the top digit; a digit is a leading zero while everything above it is zero too.
  always_comb begin
    w_lz         = '0;
    w_zero_above = r_blank;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_above = w_zero_above & (r_val[4*i +: 4] == 4'h0);
      w_lz[i]      = w_zero_above & ~r_dp[i];
    end
  end

  always_comb begin
    w_nib      = 4'h0;
    w_dp_lit   = 1'b0;
    w_slot_vis = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib      = r_val[4*i +: 4];
        w_dp_lit   = r_dp[i];
        w_slot_vis = r_en[i] & ~w_lz[i];
      end
    end
  end

  // pwm_cnt never reaches 15, so brightness 15 is permanently on and 0 permanently off.
  assign w_on  = (r_pwm_cnt < r_bright);
  assign w_vis = w_slot_vis & w_on;

  hex2seg u_hex2seg (
    .i_num (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk5) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_idx      <= '0;
      r_pwm_cnt  <= '0;
      r_val      <= '0;
      r_dp       <= '0;
      r_en       <= '0;
      r_blank    <= 1'b0;
      r_bright   <= 4'h0;
      digit      <= ANODE_OFF;
      segment    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      r_div_cnt <= w_slot_tick ? '0 : r_div_cnt + 1'b1;
      r_pwm_cnt <= (r_pwm_cnt == PWM_TOP) ? 4'h0 : r_pwm_cnt + 4'h1;
      if (w_slot_tick) r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
      // Shadows only move at the frame wrap, so a frame is never built from two input sets.
      if (w_frame_end) begin
        r_val    <= dispVal;
        r_dp     <= dp_in;
        r_en     <= digit_en;
        r_blank  <= blank_lz;
        r_bright <= brightness;
      end
      frame_tick <= w_frame_end;
      digit      <= w_vis ? ~(8'b1 << r_idx) : ANODE_OFF;
      segment    <= w_vis ? {w_seg, ~w_dp_lit} : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with NUM_DIGITS=4, DIV=8.
module tb_seg_display_scan;

  localparam int ND = 4;
  localparam int DV = 8;

  logic        clk5 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dispVal = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic [7:0]  digit;
  logic [7:0]  segment;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] SEG_T [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg_display_scan #(.NUM_DIGITS(ND), .DIV(DV)) dut (
    .clk5       (clk5),
    .reset      (reset),
    .dispVal    (dispVal),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .digit      (digit),
    .segment    (segment),
    .frame_tick (frame_tick)
  );

  always #5 clk5 = ~clk5;

  // Cycles since reset release; output after edge k reflects scan/pwm state after edge k-1.
  always @(posedge clk5) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Expected {digit, segment} after edge k for a given latched frame.
  function automatic logic [15:0] model(input int k, input logic [15:0] v, input logic [3:0] dp,
                                        input logic [3:0] en, input logic blz, input logic [3:0] br);
    int i, pc, msnz;
    logic [3:0] nib;
    logic vis;
    i = ((k - 1) / DV) % ND;
    pc = (k - 1) % 15;
    msnz = -1;
    for (int j = 0; j < ND; j++) if (v[4*j +: 4] != 4'h0) msnz = j;
    nib = v[4*i +: 4];
    vis = en[i] && (pc < int'(br)) && !(blz && i > 0 && i > msnz && !dp[i]);
    return vis ? {~(8'b1 << i), SEG_T[nib], ~dp[i]} : 16'hFFFF;
  endfunction

  task automatic sync_frame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk5);
      seen = frame_tick;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sync_frame: frame_tick=0 required 1 within 200 cycles");
    end
  endtask

  task automatic test_reset();
    dispVal = 16'h1234; digit_en = 4'hF; brightness = 4'd15; blank_lz = 1'b0; dp_in = 4'h0;
    repeat (3) @(negedge clk5);
    checks++;
    if ({digit, segment, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h/%h/%b required ff/ff/0", digit, segment, frame_tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk5);
      checks++;
      if ({digit, segment, frame_tick} !== {16'hFFFF, (k == 32)}) begin
        errors++;
        $display("FAIL first_frame k=%0d: got %h/%h/%b required ff/ff/%b", k, digit, segment, frame_tick, k == 32);
      end
    end
  endtask

  task automatic test_scan();
    logic [15:0] exp;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'h1234, 4'h0, 4'hF, 1'b0, 4'd15);
      checks++;
      if ({digit, segment, frame_tick} !== {exp, (c == 32)}) begin
        errors++;
        $display("FAIL scan cyc=%0d: got %h/%h/%b required %h/%h/%b", cyc, digit, segment, frame_tick,
                 exp[15:8], exp[7:0], c == 32);
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] exp;
    dispVal = 16'h0042; blank_lz = 1'b1; dp_in = 4'h0;
    sync_frame();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'h0042, 4'h0, 4'hF, 1'b1, 4'd15);
      checks++;
      if ({digit, segment} !== exp) begin
        errors++;
        $display("FAIL lz cyc=%0d: got %h/%h required %h/%h", cyc, digit, segment, exp[15:8], exp[7:0]);
      end
    end
    dp_in = 4'b0100;
    sync_frame();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'h0042, 4'b0100, 4'hF, 1'b1, 4'd15);
      checks++;
      if ({digit, segment} !== exp) begin
        errors++;
        $display("FAIL lz_dp cyc=%0d: got %h/%h required %h/%h", cyc, digit, segment, exp[15:8], exp[7:0]);
      end
      if (c == 20) begin
        checks++;
        if ({digit, segment} !== 16'hFB02) begin
          errors++;
          $display("FAIL lz_dp_digit2: got %h/%h required fb/02", digit, segment);
        end
      end
    end
  endtask

  task automatic test_tearing();
    logic [15:0] exp;
    dispVal = 16'h1234; blank_lz = 1'b0; dp_in = 4'h0;
    sync_frame();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'h1234, 4'h0, 4'hF, 1'b0, 4'd15);
      checks++;
      if ({digit, segment} !== exp) begin
        errors++;
        $display("FAIL tear_old cyc=%0d: got %h/%h required %h/%h", cyc, digit, segment, exp[15:8], exp[7:0]);
      end
      if (c == 12) dispVal = 16'hABCD;
    end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'hABCD, 4'h0, 4'hF, 1'b0, 4'd15);
      checks++;
      if ({digit, segment} !== exp) begin
        errors++;
        $display("FAIL tear_new cyc=%0d: got %h/%h required %h/%h", cyc, digit, segment, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_brightness();
    logic [15:0] exp;
    int lows;
    dispVal = 16'h1234; brightness = 4'd5;
    sync_frame();
    lows = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'h1234, 4'h0, 4'hF, 1'b0, 4'd5);
      checks++;
      if ({digit, segment} !== exp) begin
        errors++;
        $display("FAIL pwm5 cyc=%0d: got %h/%h required %h/%h", cyc, digit, segment, exp[15:8], exp[7:0]);
      end
      checks++;
      if ($countones(~digit) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d: digit=%h required at most one low anode", cyc, digit);
      end
      if (c <= 30 && digit != 8'hFF) lows++;
    end
    checks++;
    if (lows != 10) begin
      errors++;
      $display("FAIL pwm5_duty: %0d lit cycles of 30, required 10", lows);
    end
    brightness = 4'd0;
    sync_frame();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      checks++;
      if ({digit, segment} !== 16'hFFFF) begin
        errors++;
        $display("FAIL pwm0 cyc=%0d: got %h/%h required ff/ff", cyc, digit, segment);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp;
    brightness = 4'd15; dispVal = 16'h1234;
    sync_frame();
    repeat (20) @(negedge clk5);
    checks++;
    if (digit !== 8'hFB) begin
      errors++;
      $display("FAIL pre_reset_digit2: got %h required fb", digit);
    end
    reset = 1'b1;
    @(negedge clk5);
    checks++;
    if ({digit, segment, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got %h/%h/%b required ff/ff/0", digit, segment, frame_tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk5);
      checks++;
      if ({digit, segment, frame_tick} !== {16'hFFFF, (k == 32)}) begin
        errors++;
        $display("FAIL restart_dark k=%0d: got %h/%h/%b required ff/ff/%b", k, digit, segment, frame_tick, k == 32);
      end
    end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk5);
      exp = model(cyc, 16'h1234, 4'h0, 4'hF, 1'b0, 4'd15);
      checks++;
      if ({digit, segment} !== exp) begin
        errors++;
        $display("FAIL restart_scan cyc=%0d: got %h/%h required %h/%h", cyc, digit, segment, exp[15:8], exp[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_tearing();
    test_brightness();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
